// File: rtl/pdm_pkg.sv
// Shared types and helpers for the PDM demodulator.
// Holds the FSM state enum and the saturation-limit function.
package pdm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pdm_state_e;

  function automatic int unsigned sat_limit(input int unsigned nbits);
    return (32'd1 << nbits) - 32'd1;
  endfunction

endpackage

// File: rtl/pdm_sync.sv
// Two-flop synchronizer for the raw PDM bit.
// Only instantiated by pdm_demod when PDM_DEMOD_SYNC_EN is defined.
module pdm_sync (
  input  logic clk,
  input  logic resetn,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/pdm_demod.sv
// PDM demodulator: counts ones over a 2^NBITS-clock window and emits a saturated word.
// Optional macro PDM_DEMOD_SYNC_EN inserts a two-flop synchronizer on din.
module pdm_demod
  import pdm_pkg::*;
#(
  parameter int unsigned NBITS = 10
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             din,
  output logic [NBITS-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun
);

  localparam logic [NBITS:0]   SAT_MAX  = (NBITS + 1)'(sat_limit(NBITS));
  localparam logic [NBITS-1:0] CNT_LAST = '1;

  pdm_state_e       r_state;
  pdm_state_e       w_state_next;
  logic [NBITS:0]   r_acc;
  logic [NBITS-1:0] r_cnt;
  logic [NBITS-1:0] r_dout;
  logic             r_valid;
  logic             r_overrun;

  logic             w_din;
  logic             w_run;
  logic             w_last;
  logic [NBITS:0]   w_sum;
  logic [NBITS-1:0] w_result;

`ifdef PDM_DEMOD_SYNC_EN
  pdm_sync u_sync (
    .clk     (clk),
    .resetn  (resetn),
    .i_async (din),
    .o_sync  (w_din)
  );
`else
  assign w_din = din;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (en)  w_state_next = RUN;
      RUN:     if (!en) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_run    = (r_state == RUN);
  assign w_last   = w_run && (r_cnt == CNT_LAST);
  assign w_sum    = r_acc + {{NBITS{1'b0}}, w_din};
  assign w_result = (w_sum > SAT_MAX) ? SAT_MAX[NBITS-1:0] : w_sum[NBITS-1:0];

  // The last sample of a window is folded into the result, so acc restarts at 0 with nothing lost.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_run) begin
      r_acc <= w_last ? '0 : w_sum;
      r_cnt <= r_cnt + NBITS'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dout    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_last) begin
      if (!r_valid || dout_ready) begin
        r_dout  <= w_result;
        r_valid <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (r_valid && dout_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_pdm_demod.sv
// Randomized self-checking bench for pdm_demod (NBITS=10) against a window-level reference model.
// Directed phases cover constant, periodic, modulated, overrun and mid-window reset scenarios.
module tb_pdm_demod;

  localparam int NB  = 10;
  localparam int WIN = 1 << NB;

  logic          clk;
  logic          resetn;
  logic          en;
  logic          din;
  logic [NB-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          overrun;

  int testsRun;
  int testsFailed;
  int validCycles;
  int obsQ[$];

  int mDout;
  bit mValid;
  bit mOverrun;
  bit mRun;
  bit winQ[$];
`ifdef PDM_DEMOD_SYNC_EN
  bit mSync1;
  bit mSync2;
`endif

  pdm_demod #(.NBITS(NB)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .en         (en),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
    end
  endtask

  function automatic int satWin(input int v);
    return (v > WIN - 1) ? WIN - 1 : v;
  endfunction

  task automatic modelReset();
    mDout    = 0;
    mValid   = 1'b0;
    mOverrun = 1'b0;
    mRun     = 1'b0;
    winQ.delete();
`ifdef PDM_DEMOD_SYNC_EN
    mSync1 = 1'b0;
    mSync2 = 1'b0;
`endif
  endtask

  // One rising edge of the reference: samples taken while running are queued until a full window is reached.
  task automatic modelEdge(input bit d, input bit e, input bit r);
    bit sample;
    bit newRes;
    int total;
`ifdef PDM_DEMOD_SYNC_EN
    sample = mSync2;
    mSync2 = mSync1;
    mSync1 = d;
`else
    sample = d;
`endif
    newRes = 1'b0;
    total  = 0;
    if (mRun) begin
      winQ.push_back(sample);
      if (winQ.size() == WIN) begin
        foreach (winQ[k]) total += int'(winQ[k]);
        total = satWin(total);
        winQ.delete();
        newRes = 1'b1;
      end
    end
    if (newRes) begin
      if (!mValid || r) begin
        mDout  = total;
        mValid = 1'b1;
      end else begin
        mOverrun = 1'b1;
      end
    end else if (mValid && r) begin
      mValid = 1'b0;
    end
    mRun = e;
  endtask

  task automatic applyStimulus(input bit dinV, input bit enV, input bit readyV);
    @(negedge clk);
    din        = dinV;
    en         = enV;
    dout_ready = readyV;
    if (dout_valid) validCycles++;
    if (dout_valid && readyV) obsQ.push_back(int'(dout));
    @(posedge clk);
    modelEdge(dinV, enV, readyV);
    #1;
    checkOutput("cycle", int'({dout_valid, overrun, dout}),
                (int'(mValid) << 11) | (int'(mOverrun) << 10) | mDout);
  endtask

  task automatic applyReset();
    @(negedge clk);
    #2;
    resetn = 1'b0;
    en     = 1'b0;
    #1;
    modelReset();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    validCycles = 0;
    obsQ.delete();
  endtask

  initial begin
    int modAcc;
    int w1Ones;
    int pOnes;
    int pCnt;
    int cyc;
    int bound;
    int vals[3];
    bit d;
    bit e;
    bit prevEn;
    bit enR;

    testsRun    = 0;
    testsFailed = 0;
    validCycles = 0;
    resetn      = 1'b0;
    en          = 1'b0;
    din         = 1'b0;
    dout_ready  = 1'b0;
    modelReset();

    applyReset();
    checkOutput("rstDout", int'(dout), 0);
    checkOutput("rstValid", int'(dout_valid), 0);
    checkOutput("rstOverrun", int'(overrun), 0);

    // All ones: the 1024-count must saturate to 1023, with a single-cycle valid pulse.
    applyReset();
    repeat (WIN + 6) applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("ones_pulses", validCycles, 1);
    checkOutput("ones_results", obsQ.size(), 1);
    checkOutput("ones_dout", (obsQ.size() > 0) ? obsQ[0] : -1, WIN - 1);

    applyReset();
    repeat (2 * WIN + 10) applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("zeros_results", obsQ.size(), 2);
    checkOutput("zeros_dout0", (obsQ.size() > 0) ? obsQ[0] : -1, 0);
    checkOutput("zeros_dout1", (obsQ.size() > 1) ? obsQ[1] : -1, 0);

    applyReset();
    for (int i = 0; i < 2 * WIN + 10; i++) applyStimulus((i % 8) == 0, 1'b1, 1'b1);
    checkOutput("every8_results", obsQ.size(), 2);
    checkOutput("every8_dout0", (obsQ.size() > 0) ? obsQ[0] : -1, WIN / 8);
    checkOutput("every8_dout1", (obsQ.size() > 1) ? obsQ[1] : -1, WIN / 8);

    // First-order sigma-delta modulator; one idle-to-run cycle aligns windows with the steps.
    applyReset();
    vals   = '{120, 500, 900};
    modAcc = 0;
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 3 * WIN; i++) begin
        modAcc += vals[s];
        d = (modAcc >= WIN);
        if (d) modAcc -= WIN;
        applyStimulus(d, 1'b1, 1'b1);
      end
    end
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("mod_results", obsQ.size(), 9);
    for (int s = 0; s < 3; s++) begin
      for (int w = 1; w < 3; w++) begin
        int idx;
        int got;
        idx = 3 * s + w;
        got = (obsQ.size() > idx) ? obsQ[idx] : -100;
        checkOutput($sformatf("mod%0d_win%0d_within1", vals[s], w + 1),
                    ((got - vals[s] >= -1) && (got - vals[s] <= 1)) ? 1 : 0, 1);
      end
    end

    // Consumer stalled for two windows: first result held, second dropped.
    applyReset();
    w1Ones = 0;
    for (int i = 0; i < 2 * WIN + 10; i++) begin
      d = 1'($urandom_range(0, 1));
      if (i >= 1 && i <= WIN) w1Ones += int'(d);
      applyStimulus(d, 1'b1, 1'b0);
    end
    checkOutput("stall_held_dout", int'(dout), satWin(w1Ones));
    checkOutput("stall_valid", int'(dout_valid), 1);
    checkOutput("stall_overrun", int'(overrun), 1);
    repeat (50) applyStimulus(1'($urandom_range(0, 1)), 1'b1, 1'b1);
    checkOutput("overrun_sticky", int'(overrun), 1);

    bound = 0;
    while (winQ.size() != 500 && bound < 3 * WIN) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'b1, 1'b1);
      bound++;
    end
    checkOutput("reach_cnt500", winQ.size(), 500);
    checkOutput("pre_reset_overrun", int'(overrun), 1);

    // Asynchronous reset between clock edges discards the partial window.
    @(negedge clk);
    #2;
    resetn = 1'b0;
    en     = 1'b0;
    #1;
    checkOutput("async_rst_dout", int'(dout), 0);
    checkOutput("async_rst_valid", int'(dout_valid), 0);
    checkOutput("async_rst_overrun", int'(overrun), 0);
    modelReset();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    obsQ.delete();

    // en low for 100 clocks mid-window; a sample counts when en was high on the previous edge.
    pOnes  = 0;
    pCnt   = 0;
    cyc    = 0;
    prevEn = 1'b0;
    while (pCnt < WIN && cyc < 3 * WIN) begin
      e = !(cyc >= 300 && cyc < 400);
      d = 1'($urandom_range(0, 1));
      if (prevEn) begin
        pOnes += int'(d);
        pCnt++;
      end
      applyStimulus(d, e, 1'b1);
      prevEn = e;
      cyc++;
    end
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("pause_samples", pCnt, WIN);
    checkOutput("pause_results", obsQ.size(), 1);
    checkOutput("pause_exact", (obsQ.size() > 0) ? obsQ[0] : -1, satWin(pOnes));

    // Free-running random traffic with random back-pressure and enable gaps.
    applyReset();
    enR = 1'b1;
    for (int i = 0; i < 9000; i++) begin
      if ($urandom_range(0, 63) == 0) enR = ~enR;
      applyStimulus(1'($urandom_range(0, 1)), enR, $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
